// File: rtl/am2940_defs.sv
// Shared constants for the Am2940 datapath registers: default width and the
// active-low load strobe encodings.
package am2940_defs;

    localparam int   AM2940_WIDTH = 4;

    localparam logic PLAR_LOAD = 1'b0;
    localparam logic PLAR_HOLD = 1'b1;

endpackage

// File: rtl/am2940_load_register.sv
// Am2940 load register: captures di on a rising clk edge while plar is low.
// The output is named dout because "do" is a reserved word in SystemVerilog.
module am2940_load_register
    import am2940_defs::*;
#(
    parameter int               WIDTH     = AM2940_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             plar,
    input  logic [WIDTH-1:0] di,
    output logic [WIDTH-1:0] dout
);

    // Reset outranks the load strobe when both are asserted on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n)
            dout <= RESET_VAL;
        else if (plar == PLAR_LOAD)
            dout <= di;
    end

endmodule

// File: tb/tb_am2940_load_register.sv
// Directed bench for am2940_load_register with hand-computed expected values.
module tb_am2940_load_register;

    logic       clk;
    logic       rst_n;
    logic       plar;
    logic [3:0] di;
    logic [3:0] dout;

    int n_checks = 0;
    int n_errors = 0;

    am2940_load_register #(.WIDTH(4), .RESET_VAL(4'b0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .plar  (plar),
        .di    (di),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] walk [4];

    initial begin
        walk[0] = 4'b0001; walk[1] = 4'b0010; walk[2] = 4'b0100; walk[3] = 4'b1000;

        rst_n = 1'b0; plar = 1'b0; di = 4'b1010;
        step();
        chk("reset", dout, 4'b0000);
        rst_n = 1'b1; plar = 1'b1;
        step();
        chk("reset_release_hold", dout, 4'b0000);

        plar = 1'b0; di = 4'b1111;
        step();
        chk("load_1", dout, 4'b1111);
        step();
        chk("load_2", dout, 4'b1111);

        plar = 1'b1; di = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold", dout, 4'b1111);
        end
        for (int i = 0; i < 3; i++) begin
            #2 di = 4'b1010;
            #2 di = 4'b0011;
            chk("hold_di_toggle_mid", dout, 4'b1111);
            step();
            chk("hold_di_toggle", dout, 4'b1111);
        end

        plar = 1'b0; di = 4'b0000;
        step();
        chk("reload_zero", dout, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            di = walk[i];
            #2 chk("walk_lag", dout, (i == 0) ? 4'b0000 : walk[i-1]);
            step();
            chk("walk", dout, walk[i]);
        end

        di = 4'b1010;
        step();
        chk("prio_preload", dout, 4'b1010);
        rst_n = 1'b0; plar = 1'b0; di = 4'b1111;
        step();
        chk("reset_priority", dout, 4'b0000);
        rst_n = 1'b1;
        step();
        chk("load_after_reset", dout, 4'b1111);

        plar = 1'b1; di = 4'b0000;
        step();
        chk("setup_hold", dout, 4'b1111);
        @(negedge clk);
        di = 4'b0110; plar = 1'b0;
        #1 chk("setup_before_edge", dout, 4'b1111);
        step();
        chk("setup_capture", dout, 4'b0110);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
